// File: rtl/spectrum_pkg.sv
// -----------------------------------------------------------------------------
// spectrum_pkg
// Shared definitions for the spectrum power unit:
//   - frame_state_t : frame-level state (stIdle, stRun, stResync)
//   - saturate()    : clamp an unsigned value to a given bit width
//   - SHIFT0_DEFAULT, AVG_SHIFT_DEFAULT : default window / averaging shifts
// No ports (package).
// -----------------------------------------------------------------------------
package spectrum_pkg;

    typedef enum logic [1:0] {
        stIdle   = 2'd0,
        stRun    = 2'd1,
        stResync = 2'd2
    } frame_state_t;

    localparam int SHIFT0_DEFAULT    = 23;
    localparam int AVG_SHIFT_DEFAULT = 2;

    // Returns all ones in the low 'width' bits when value does not fit,
    // otherwise the value itself. Callers slice the result to their width.
    function automatic logic [31:0] saturate(input logic [63:0] value,
                                             input int unsigned width);
        logic [63:0] limit;
        limit = 64'd1 << width;
        if (value >= limit) begin
            return 32'(limit - 64'd1);
        end
        return value[31:0];
    endfunction

endpackage

// File: rtl/spectrum_avg_ram.sv
// -----------------------------------------------------------------------------
// spectrum_avg_ram
// Simple dual-port RAM holding the per-bin running averages. One write port,
// one read port with a single cycle of read latency. The whole module is only
// compiled when SPECTRUM_AVG_EN is defined, so the default build carries no
// RAM at all.
// Ports:
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (sampled on the clock edge)
//   rd_data : registered read data
// -----------------------------------------------------------------------------
`ifdef SPECTRUM_AVG_EN
module spectrum_avg_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; a reset would turn it into
    // flops instead of a RAM macro. The first frame after reset overwrites
    // every bin it touches, so stale contents are never averaged in.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule
`endif

// File: rtl/spectrum_power_unit.sv
// -----------------------------------------------------------------------------
// spectrum_power_unit
// Turns the complex FFT output stream into a byte-wide power spectrum:
// P = re^2 + im^2, window shift by (SHIFT0 - gain), saturate to OUT_W bits,
// optional exponential averaging across frames. Tracks frame framing, the
// per-frame peak bin (DC excluded) and flags framing errors.
// Build option: define SPECTRUM_AVG_EN to compile in per-bin averaging.
// Ports:
//   ckFft / rstFft        : clock, synchronous active-high reset
//   sGain                 : gain select, taken at bin 0 of each frame
//   sRe / sIm             : signed real / imaginary input
//   sValid / sLast / sReady : input handshake, last bin of frame
//   flgFreqSampleValid    : output sample valid
//   addrFreq / byteFreqSample : output bin address and power byte
//   flgFrameDone          : pulse with the last bin of a good frame
//   flgSyncErr            : pulse with the sample that broke framing
//   peakAddr / peakByte   : largest bin of the last good frame
// -----------------------------------------------------------------------------
module spectrum_power_unit
    import spectrum_pkg::*;
#(
    parameter int NPOINT    = 1024,
    parameter int ADDR_W    = $clog2(NPOINT),
    parameter int IN_W      = 19,
    parameter int OUT_W     = 8,
    parameter int GAIN_W    = 3,
    parameter int SHIFT0    = SHIFT0_DEFAULT,
    parameter int AVG_SHIFT = AVG_SHIFT_DEFAULT
) (
    input  logic              ckFft,
    input  logic              rstFft,
    input  logic [GAIN_W-1:0] sGain,
    input  logic [IN_W-1:0]   sRe,
    input  logic [IN_W-1:0]   sIm,
    input  logic              sValid,
    input  logic              sLast,
    output logic              sReady,
    output logic              flgFreqSampleValid,
    output logic [ADDR_W-1:0] addrFreq,
    output logic [OUT_W-1:0]  byteFreqSample,
    output logic              flgFrameDone,
    output logic              flgSyncErr,
    output logic [ADDR_W-1:0] peakAddr,
    output logic [OUT_W-1:0]  peakByte
);

    localparam int P_W = 2 * IN_W;
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NPOINT - 1);

    if (NPOINT < 8 || (1 << ADDR_W) != NPOINT ||
        SHIFT0 < (1 << GAIN_W) - 1 || AVG_SHIFT < 0) begin : g_cfg_check
        $error("spectrum_power_unit: unsupported parameter combination");
    end

    // ---------------- frame control ----------------
    frame_state_t      state, state_next;
    logic [ADDR_W-1:0] bin_cnt, bin_next;
    logic [GAIN_W-1:0] gain_lat, emit_gain;
    logic              accept, emit, emit_err, emit_done;

    assign sReady = ~rstFft;
    assign accept = sValid & sReady;

    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_next = state;
        bin_next   = bin_cnt;
        emit       = 1'b0;
        emit_err   = 1'b0;
        emit_done  = 1'b0;
        emit_gain  = gain_lat;
        if (accept) begin
            unique case (state)
                stIdle, stRun: begin
                    emit = 1'b1;
                    // Bin 0 uses the gain presented with it, later bins the latched one.
                    if (state == stIdle) emit_gain = sGain;
                    if (sLast) begin
                        state_next = stIdle;
                        bin_next   = '0;
                        if (state == stRun && bin_cnt == LAST_BIN) emit_done = 1'b1;
                        else                                       emit_err  = 1'b1;
                    end else if (state == stRun && bin_cnt == LAST_BIN) begin
                        // Frame overran without sLast: drop input until the next sLast.
                        emit_err   = 1'b1;
                        state_next = stResync;
                        bin_next   = '0;
                    end else begin
                        state_next = stRun;
                        bin_next   = bin_cnt + ADDR_W'(1);
                    end
                end
                stResync: if (sLast) state_next = stIdle;
                default:  state_next = stIdle;
            endcase
        end
    end

    // ---------------- pipeline ----------------
    logic              v1, err1, done1, v2, err2, done2;
    logic [ADDR_W-1:0] addr1, addr2;
    logic [GAIN_W-1:0] gain1;
    logic [P_W-1:0]    re_sq1, im_sq1, w2;
    logic signed [P_W-1:0] re_ext, im_ext;
    logic [31:0]       shamt;

    assign re_ext = P_W'($signed(sRe));
    assign im_ext = P_W'($signed(sIm));
    assign shamt  = 32'(SHIFT0) - 32'(gain1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge ckFft) begin
        if (rstFft) begin
            state    <= stIdle;
            bin_cnt  <= '0;
            gain_lat <= '0;
            v1       <= 1'b0;
            err1     <= 1'b0;
            done1    <= 1'b0;
            v2       <= 1'b0;
            err2     <= 1'b0;
            done2    <= 1'b0;
        end else begin
            state   <= state_next;
            bin_cnt <= bin_next;
            if (accept && state == stIdle) gain_lat <= sGain;
            v1    <= emit;
            err1  <= emit_err;
            done1 <= emit_done;
            v2    <= v1;
            err2  <= err1;
            done2 <= done1;
        end
    end

    // Datapath registers are qualified by the valids above, so they need no reset.
    always_ff @(posedge ckFft) begin
        addr1  <= bin_cnt;
        gain1  <= emit_gain;
        re_sq1 <= $unsigned(re_ext * re_ext);
        im_sq1 <= $unsigned(im_ext * im_ext);
        addr2  <= addr1;
        w2     <= (re_sq1 + im_sq1) >> shamt;   // sum cannot exceed 2^(P_W-1)
    end

    // ---------------- stage 3: saturate / average ----------------
    logic [OUT_W-1:0] sat3, out3;
    assign sat3 = OUT_W'(saturate(64'(w2), OUT_W));

`ifdef SPECTRUM_AVG_EN
    localparam int ACC_W = OUT_W + AVG_SHIFT;
    logic [ACC_W-1:0]      acc_old, acc_in, acc_new;
    logic signed [ACC_W:0] acc_diff, acc_step;
    logic                  first_frame, init1, init2;

    assign acc_in = ACC_W'(sat3) << AVG_SHIFT;

    always_comb begin
        acc_diff = $signed({1'b0, acc_in}) - $signed({1'b0, acc_old});
        acc_step = acc_diff >>> AVG_SHIFT;
        acc_new  = init2 ? acc_in : ACC_W'({1'b0, acc_old} + $unsigned(acc_step));
    end
    assign out3 = OUT_W'(acc_new >> AVG_SHIFT);

    // The first frame after reset seeds the RAM instead of averaging into
    // whatever it held before.
    always_ff @(posedge ckFft) begin
        if (rstFft)                       first_frame <= 1'b1;
        else if (emit_err || emit_done)   first_frame <= 1'b0;
        init1 <= first_frame;
        init2 <= init1;
    end

    spectrum_avg_ram #(
        .DEPTH  (NPOINT),
        .ADDR_W (ADDR_W),
        .DATA_W (ACC_W)
    ) u_avg_ram (
        .clk     (ckFft),
        .wr_en   (v2 & ~rstFft),
        .wr_addr (addr2),
        .wr_data (acc_new),
        .rd_addr (addr1),
        .rd_data (acc_old)
    );
`else
    assign out3 = sat3;
`endif

    // ---------------- outputs and peak tracker ----------------
    logic [ADDR_W-1:0] trk_addr;
    logic [OUT_W-1:0]  trk_byte;
    logic              beats;

    // Strictly greater keeps the lowest bin on ties; bin 0 (DC) never competes.
    assign beats = (addr2 != '0) && (out3 > trk_byte);

    always_ff @(posedge ckFft) begin
        if (rstFft) begin
            flgFreqSampleValid <= 1'b0;
            addrFreq           <= '0;
            byteFreqSample     <= '0;
            flgFrameDone       <= 1'b0;
            flgSyncErr         <= 1'b0;
            peakAddr           <= '0;
            peakByte           <= '0;
            trk_addr           <= '0;
            trk_byte           <= '0;
        end else begin
            flgFreqSampleValid <= v2;
            flgFrameDone       <= done2;
            flgSyncErr         <= err2;
            if (v2) begin
                addrFreq       <= addr2;
                byteFreqSample <= out3;
                if (addr2 == '0) begin
                    trk_addr <= '0;
                    trk_byte <= '0;
                end else if (beats) begin
                    trk_addr <= addr2;
                    trk_byte <= out3;
                end
                if (done2) begin
                    peakAddr <= beats ? addr2 : trk_addr;
                    peakByte <= beats ? out3  : trk_byte;
                end
            end
        end
    end

endmodule
